timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter width in bits (legal range 2..16).
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent timer channels (legal range 1..16); CW = max(1, clog2(CHANNELS)).
REQ-003 Ports SHALL be exactly as follows:
- clk  in  1  sole clock; all state updates on posedge.
- sys_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  shared decrement tick; one-cycle strobe, e.g. 1 Hz.
- start_timer  in  1  load/start strobe for channel start_chan.
- start_chan  in  CW  channel addressed by start_timer.
- clk_value  in  WIDTH  initial count and reload value.
- periodic  in  1  mode sampled with start_timer: 1 = auto-reload, 0 = one-shot.
- stop_timer  in  1  abort strobe for channel stop_chan.
- stop_chan  in  CW  channel addressed by stop_timer.
- read_chan  in  CW  channel whose count drives countdown.
- expired  out  CHANNELS  per-channel one-cycle expiry pulse.
- active  out  CHANNELS  per-channel running flag.
- countdown  out  WIDTH  current count of read_chan.
- any_expired  out  1  OR-reduction of expired.

Function
REQ-004 Each channel SHALL hold: count (WIDTH), reload (WIDTH), active (1), mode (1), expired (1), all registered.
REQ-005 On start_timer with start_chan < CHANNELS, the addressed channel SHALL, at the next edge, set count = clk_value, reload = clk_value, mode = periodic and active = 1.
REQ-006 Start with clk_value == 0 SHALL leave count = 0 and active = 0, force mode = 0, and assert expired for one cycle on the following cycle, independent of enable.
REQ-007 An active channel with count > 1 SHALL decrement count by 1 on each cycle where enable = 1.
REQ-008 An active channel with count == 1 and enable = 1 SHALL, in one-shot mode, set count = 0 and active = 0; in periodic mode, it SHALL set count = reload and keep active = 1.
REQ-009 expired[i] SHALL assert for exactly one clk cycle: the cycle after the edge where the REQ-008 transition occurred. It SHALL never be held high for two consecutive cycles due to a single expiry.
REQ-010 An inactive channel SHALL ignore enable and hold count.
REQ-011 stop_timer with stop_chan < CHANNELS SHALL clear active for that channel at the next edge, hold count, and generate no expiry.
REQ-012 Simultaneous events on the same channel in one cycle:
- start_timer beats stop_timer.
- start_timer beats enable (the start value is loaded, not decremented).
- stop_timer beats an enable-driven expiry (no expired pulse).
REQ-013 Start and stop addressed to different channels in the same cycle SHALL both take effect.
REQ-014 start_chan or stop_chan >= CHANNELS SHALL be ignored, with no state change.
REQ-015 countdown SHALL be a combinational mux of count[read_chan]; read_chan >= CHANNELS SHALL yield 0.
REQ-016 active SHALL reflect the registered active flags directly; any_expired SHALL be the combinational OR of expired.
REQ-017 No arithmetic SHALL wrap: count never decrements below 0.

Reset
REQ-018 sys_reset_n = 0 SHALL asynchronously clear all count, reload, active, mode and expired registers; all outputs SHALL read 0 while reset is held.
REQ-019 Reset asserted mid-count SHALL abort every channel with no expired pulse, and deassertion SHALL leave all channels idle until a new start_timer.

Configuration
REQ-020 Macro TIMER_BANK_PERIODIC_EN defined: periodic mode SHALL behave per REQ-005 and REQ-008.
REQ-021 Macro TIMER_BANK_PERIODIC_EN undefined: the periodic input SHALL be ignored, mode SHALL be constantly 0, and the reload registers SHALL not be synthesised; all channels run one-shot.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Ch0 one-shot: start, clk_value = 3, one enable pulse every 4 clks -> countdown reads 3, 2, 1, 0; expired[0] high for exactly 1 clk after the third tick; active[0] = 0.
- Ch1 periodic (PERIODIC_EN defined): clk_value = 2, continuous enable -> expired[1] pulses every 2 clks; count sequence 2, 1, 2, 1; active[1] stays 1.
- Ch2 start with clk_value = 0 and enable = 0 -> expired[2] = 1 on the next cycle only; active[2] = 0.
- Ch3 running at count 5: stop_timer -> active[3] = 0, count holds 5, no expiry. Same cycle start_timer ch3 value 9 plus stop ch3 -> count = 9, active = 1.
- Ch0 count 1: enable plus stop_timer ch0 in the same cycle -> no expired pulse, count holds 1. start_chan = CHANNELS -> no change.
- Two channels mid-count: assert sys_reset_n = 0 asynchronously between edges -> all outputs 0 immediately; after release, no expiry until restarted.

Source files
------------

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of independent countdown timers with a shared decrement tick.
// Define TIMER_BANK_PERIODIC_EN to enable auto-reload (periodic) mode; otherwise every channel is one-shot.
module timer_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                sys_reset_n,
    input  logic                enable,
    input  logic                start_timer,
    input  logic [CW-1:0]       start_chan,
    input  logic [WIDTH-1:0]    clk_value,
    input  logic                periodic,
    input  logic                stop_timer,
    input  logic [CW-1:0]       stop_chan,
    input  logic [CW-1:0]       read_chan,
    output logic [CHANNELS-1:0] expired,
    output logic [CHANNELS-1:0] active,
    output logic [WIDTH-1:0]    countdown,
    output logic                any_expired
);

    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [CHANNELS-1:0] active_q, active_d;
    logic [CHANNELS-1:0] expired_q, expired_d;
    logic [CHANNELS-1:0] start_sel, stop_sel;

`ifdef TIMER_BANK_PERIODIC_EN
    logic [WIDTH-1:0]    reload_q [CHANNELS];
    logic [WIDTH-1:0]    reload_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
`else
    logic unused_periodic;
    assign unused_periodic = periodic;
`endif

    // Out-of-range channel numbers never match any index, so they are ignored.
    always_comb begin
        start_sel = '0;
        stop_sel  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            start_sel[i] = start_timer && (start_chan == CW'(i));
            stop_sel[i]  = stop_timer && (stop_chan == CW'(i));
        end
    end

    // Priority per channel: start, then stop, then the enable tick.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i]   = count_q[i];
            active_d[i]  = active_q[i];
            expired_d[i] = 1'b0;
`ifdef TIMER_BANK_PERIODIC_EN
            reload_d[i]  = reload_q[i];
            mode_d[i]    = mode_q[i];
`endif
            if (start_sel[i]) begin
                count_d[i]   = clk_value;
                active_d[i]  = |clk_value;
                expired_d[i] = ~|clk_value;
`ifdef TIMER_BANK_PERIODIC_EN
                reload_d[i]  = clk_value;
                mode_d[i]    = periodic && (|clk_value);
`endif
            end else if (stop_sel[i]) begin
                active_d[i] = 1'b0;
            end else if (active_q[i] && enable) begin
                if (count_q[i] > WIDTH'(1)) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end else begin
                    expired_d[i] = 1'b1;
                    count_d[i]   = '0;
                    active_d[i]  = 1'b0;
`ifdef TIMER_BANK_PERIODIC_EN
                    if (mode_q[i]) begin
                        count_d[i]  = reload_q[i];
                        active_d[i] = 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
            end
            active_q  <= '0;
            expired_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
            end
            active_q  <= active_d;
            expired_q <= expired_d;
        end
    end

`ifdef TIMER_BANK_PERIODIC_EN
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                reload_q[i] <= '0;
            end
            mode_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                reload_q[i] <= reload_d[i];
            end
            mode_q <= mode_d;
        end
    end
`endif

    always_comb begin
        countdown = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (read_chan == CW'(i)) begin
                countdown = count_q[i];
            end
        end
    end

    assign active      = active_q;
    assign expired     = expired_q;
    assign any_expired = |expired_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed and randomized checks of timer_bank against a behavioural model.
module tb_timer_bank;

    localparam int W  = 8;
    localparam int CH = 5;
    localparam int CW = 3;
`ifdef TIMER_BANK_PERIODIC_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic          clk, sys_reset_n, enable, start_timer, periodic, stop_timer;
    logic [CW-1:0] start_chan, stop_chan, read_chan;
    logic [W-1:0]  clk_value;
    logic [CH-1:0] expired, active;
    logic [W-1:0]  countdown;
    logic          any_expired;

    timer_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .sys_reset_n(sys_reset_n), .enable(enable),
        .start_timer(start_timer), .start_chan(start_chan), .clk_value(clk_value),
        .periodic(periodic), .stop_timer(stop_timer), .stop_chan(stop_chan),
        .read_chan(read_chan), .expired(expired), .active(active),
        .countdown(countdown), .any_expired(any_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_cnt [CH];
    int m_rel [CH];
    bit m_act [CH];
    bit m_per [CH];
    logic [CH-1:0] m_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_act[i] = 0; m_per[i] = 0;
        end
        m_exp = '0;
    endtask

    // A timer that reaches the end of its count fires once, then reloads or goes idle.
    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            m_exp[i] = 1'b0;
            if (start_timer && int'(start_chan) == i) begin
                m_cnt[i] = int'(clk_value);
                m_rel[i] = int'(clk_value);
                m_act[i] = (clk_value != 0);
                m_per[i] = PER_EN && periodic && (clk_value != 0);
                m_exp[i] = (clk_value == 0);
            end else if (stop_timer && int'(stop_chan) == i) begin
                m_act[i] = 1'b0;
            end else if (m_act[i] && enable) begin
                if (m_cnt[i] >= 2) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end else begin
                    m_exp[i] = 1'b1;
                    m_cnt[i] = m_per[i] ? m_rel[i] : 0;
                    m_act[i] = m_per[i];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("active%0d", i), 32'(active[i]), 32'(m_act[i]));
            chk($sformatf("expired%0d", i), 32'(expired[i]), 32'(m_exp[i]));
        end
        chk("countdown", 32'(countdown), (int'(read_chan) < CH) ? m_cnt[read_chan] : 0);
        chk("any_expired", 32'(any_expired), 32'(|m_exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clr();
        enable = 0; start_timer = 0; stop_timer = 0; periodic = 0;
    endtask

    task automatic start(input int ch, input int val, input bit per);
        start_timer = 1; start_chan = CW'(ch); clk_value = W'(val); periodic = per;
    endtask

    int pulses;
    int exp_cd [4];
    int exp_ex [4];

    initial begin
        sys_reset_n = 0; clr();
        start_chan = 0; stop_chan = 0; read_chan = 0; clk_value = 0;
        model_reset();
        #1;
        check_all();
        chk("reset_countdown", 32'(countdown), 0);
        @(posedge clk); #1;
        sys_reset_n = 1;

        // One-shot countdown from 3 with a tick every 4 clocks
        read_chan = 0;
        start(0, 3, 0); step(); clr();
        chk("s1_load", 32'(countdown), 3);
        pulses = 0;
        for (int k = 1; k <= 3; k++) begin
            enable = 1; step(); enable = 0;
            pulses += int'(expired[0]);
            chk("s1_count", 32'(countdown), 32'(3 - k));
            for (int j = 0; j < 3; j++) begin
                step();
                pulses += int'(expired[0]);
            end
        end
        chk("s1_pulses", pulses, 1);
        chk("s1_idle", 32'(active[0]), 0);

        // Periodic reload from 2 under continuous enable
        read_chan = 1;
        start(1, 2, 1); enable = 1; step(); start_timer = 0;
        chk("s2_load", 32'(countdown), 2);
        if (PER_EN) begin
            exp_cd = '{1, 2, 1, 2}; exp_ex = '{0, 1, 0, 1};
        end else begin
            exp_cd = '{1, 0, 0, 0}; exp_ex = '{0, 1, 0, 0};
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s2_count", 32'(countdown), exp_cd[k]);
            chk("s2_expired", 32'(expired[1]), exp_ex[k]);
        end
        chk("s2_active", 32'(active[1]), 32'(PER_EN));
        clr(); stop_timer = 1; stop_chan = 1; step(); clr();

        // Start with zero fires immediately and stays idle
        start(2, 0, 1); step(); clr();
        chk("s3_expired", 32'(expired[2]), 1);
        chk("s3_active", 32'(active[2]), 0);
        step();
        chk("s3_once", 32'(expired[2]), 0);

        // Stop holds the count; start beats stop on the same channel
        read_chan = 3;
        start(3, 7, 0); step(); clr();
        enable = 1; step(); step(); enable = 0;
        chk("s4_five", 32'(countdown), 5);
        stop_timer = 1; stop_chan = 3; step(); clr();
        chk("s4_stopped", 32'(active[3]), 0);
        chk("s4_hold", 32'(countdown), 5);
        chk("s4_noexp", 32'(expired[3]), 0);
        enable = 1; step(); step(); enable = 0;
        chk("s4_ignore_en", 32'(countdown), 5);
        start(3, 9, 0); stop_timer = 1; stop_chan = 3; step(); clr();
        chk("s4_restart", 32'(countdown), 9);
        chk("s4_restart_act", 32'(active[3]), 1);
        start(1, 4, 0); stop_timer = 1; stop_chan = 3; step(); clr();
        chk("s4_both_stop", 32'(active[3]), 0);
        chk("s4_both_start", 32'(active[1]), 1);

        // Stop beats expiry at count 1; out-of-range start and read
        read_chan = 0;
        start(0, 2, 0); step(); clr();
        enable = 1; step(); enable = 0;
        chk("s5_one", 32'(countdown), 1);
        enable = 1; stop_timer = 1; stop_chan = 0; step(); clr();
        chk("s5_noexp", 32'(expired[0]), 0);
        chk("s5_hold", 32'(countdown), 1);
        step();
        chk("s5_noexp_late", 32'(expired[0]), 0);
        start(CH, 7, 0); step(); clr();
        chk("s5_oor_start", 32'(countdown), 1);
        chk("s5_oor_act", 32'(active), 32'(5'b00010));
        read_chan = CH; step();
        chk("s5_oor_read", 32'(countdown), 0);

        // Asynchronous reset mid-count
        read_chan = 0;
        start(0, 10, 0); step();
        start(2, 10, 0); step(); clr();
        enable = 1; step(); step(); step();
        #2 sys_reset_n = 0;
        #1 model_reset();
        check_all();
        chk("s6_active", 32'(active), 0);
        chk("s6_count", 32'(countdown), 0);
        @(posedge clk); #1;
        check_all();
        sys_reset_n = 1;
        for (int k = 0; k < 15; k++) step();
        chk("s6_quiet", 32'(any_expired), 0);
        chk("s6_idle", 32'(active), 0);

        // Randomized traffic including out-of-range channels
        for (int k = 0; k < 400; k++) begin
            enable      = ($urandom % 3) == 0;
            start_timer = ($urandom % 4) == 0;
            start_chan  = CW'($urandom % 8);
            clk_value   = W'($urandom % 5);
            periodic    = $urandom % 2;
            stop_timer  = ($urandom % 6) == 0;
            stop_chan   = CW'($urandom % 8);
            read_chan   = CW'($urandom % 8);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
